uart_tx_param: RTL

- Parametrised UART transmitter; next generation of the fixed 8N1 UART TX top.
- Adds generic data width, run-time parity (none/even/odd) and 1 or 2 stop bits.
- Adds a one-entry holding buffer with a ready/valid handshake, so frames can go out back-to-back with no idle gap.
- Sits between the parallel system bus and the serial pad.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_tx_param.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
// Frame config is captured once per frame so mid-frame input changes are ignored.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef struct packed {
        logic par_en;
        logic par_bit;
        logic stop2;
    } frame_cfg_t;

    // Serial bit-times in one frame: start + data + parity + stop(s).
    function automatic int unsigned frame_bits(
        input int unsigned data_w,
        input logic        par_en,
        input logic        stop2
    );
        return 32'd2 + data_w + {31'd0, par_en} + {31'd0, stop2};
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// clr holds the counter at zero while idle and restarts it on each frame load.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with generic width, run-time parity/stop config and a
// one-word holding buffer so frames can be sent back-to-back.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] p_data,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic              stop2,
    output logic              tx_out,
    output logic              busy,
    output logic              uart_tx_done
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    tx_state_t         state;
    tx_state_t         state_d;
    logic [DATA_W-1:0] buf_q;
    logic              buf_full;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] sh_d;
    logic [BIT_W-1:0]  bit_q;
    logic [BIT_W-1:0]  bit_d;
    logic              stop_q;
    logic              stop_d;
    frame_cfg_t        cfg_q;
    frame_cfg_t        cfg_d;
    logic              tx_q;
    logic              tx_d;
    logic              tick;
    logic              load;
    logic              done;
    logic              accept;
    logic              baud_clr;

    assign accept       = data_valid && !buf_full;
    assign data_ready   = !buf_full;
    assign baud_clr     = load || (state == IDLE);
    assign tx_out       = tx_q;
    assign busy         = (state != IDLE);
    assign uart_tx_done = done;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (baud_clr),
        .tick(tick)
    );

    always_comb begin
        state_d = state;
        sh_d    = sh_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        cfg_d   = cfg_q;
        tx_d    = tx_q;
        load    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                tx_d = 1'b1;
                load = buf_full;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = sh_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        if (cfg_q.par_en) begin
                            state_d = PARITY;
                            tx_d    = cfg_q.par_bit;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (cfg_q.stop2 && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        done = 1'b1;
                        if (buf_full) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // A load both starts a frame from idle and chains one after a stop bit.
        if (load) begin
            state_d       = START;
            sh_d          = buf_q;
            bit_d         = '0;
            stop_d        = 1'b0;
            tx_d          = 1'b0;
            cfg_d.par_en  = par_en;
            cfg_d.stop2   = stop2;
            cfg_d.par_bit = (par_typ == PAR_ODD) ? ~(^buf_q) : ^buf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sh_q   <= '0;
            bit_q  <= '0;
            stop_q <= 1'b0;
            cfg_q  <= '0;
            tx_q   <= 1'b1;
        end else begin
            state  <= state_d;
            sh_q   <= sh_d;
            bit_q  <= bit_d;
            stop_q <= stop_d;
            cfg_q  <= cfg_d;
            tx_q   <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_q    <= '0;
        end else begin
            if (load) begin
                buf_full <= 1'b0;
            end
            if (accept) begin
                buf_full <= 1'b1;
                buf_q    <= p_data;
            end
        end
    end

endmodule
